// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes and decode helpers shared by the issue controller
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_ASR   = 4'b1000;
  localparam logic [3:0] ALU_CMPEQ = 4'b1001;
  localparam logic [3:0] ALU_CMPLT = 4'b1010;
  localparam logic [3:0] ALU_CMPGT = 4'b1011;
  localparam logic [3:0] ALU_OP_MAX = 4'b1011;

  // Only ADD and SUB produce a meaningful overflow flag.
  function automatic logic is_addsub(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - issue and result handshakes of the ALU issue controller
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_z;
  logic              out_ovf;
  logic [TAG_W-1:0]  out_tag;
  logic              out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_z, out_ovf, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_z, out_ovf, out_tag, out_illegal
  );
endinterface

// File: rtl/alu_res_fifo.sv
// rtl/alu_res_fifo.sv - synchronous result FIFO with push/pop and occupancy count
module alu_res_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && full));
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues ops to the registered 64-bit ALU and collects results with credit backpressure
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 5,
  parameter int RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  alu_issue_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_z,
  input  logic              alu_ovf,
  input  logic              stat_clr,
  output logic [31:0]       stat_ops,
  output logic              stat_ovf_sticky
);
  localparam int CW = $clog2(RES_DEPTH) + 1;
  localparam int RW = DATA_W + TAG_W + 2;

  logic             s1_valid, s1_illegal, s1_addsub;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid, s2_illegal, s2_addsub;
  logic [TAG_W-1:0] s2_tag;
  logic             accept, pop, fifo_full;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occupancy;
  logic [RW-1:0]    wdata, rdata;

  // Every op in flight holds a FIFO credit, so S2 can never find the FIFO full.
  assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid} + {{CW{1'b0}}, s2_valid};
  assign bus.in_ready = !reset && (occupancy < (CW+1)'(RES_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      s1_tag     <= '0;
      s1_illegal <= 1'b0;
      s1_addsub  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        alu_a      <= bus.in_a;
        alu_b      <= bus.in_b;
        alu_ctrl   <= bus.in_op;
        s1_tag     <= bus.in_tag;
        s1_illegal <= is_illegal(bus.in_op);
        s1_addsub  <= is_addsub(bus.in_op);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      s2_tag     <= '0;
      s2_illegal <= 1'b0;
      s2_addsub  <= 1'b0;
    end else begin
      s2_valid   <= s1_valid;
      s2_tag     <= s1_tag;
      s2_illegal <= s1_illegal;
      s2_addsub  <= s1_addsub;
    end
  end

  // Illegal ops retire with a zero result whatever the ALU produced.
  assign wdata = {alu_z & {DATA_W{!s2_illegal}}, alu_ovf & s2_addsub, s2_tag, s2_illegal};

  alu_res_fifo #(.WIDTH(RW), .DEPTH(RES_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s2_valid),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .count (fifo_count),
    .full  (fifo_full)
  );

  assign {bus.out_z, bus.out_ovf, bus.out_tag, bus.out_illegal} = rdata;
  assign bus.out_valid = (fifo_count != '0);
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stat_ops        <= '0;
      stat_ovf_sticky <= 1'b0;
    end else if (pop) begin
      stat_ops        <= stat_ops + 32'd1;
      stat_ovf_sticky <= stat_ovf_sticky | bus.out_ovf;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] alu_a, alu_b, alu_z;
  logic [3:0]        alu_ctrl;
  logic              alu_ovf;
  logic              stat_clr;
  logic [31:0]       stat_ops;
  logic              stat_ovf_sticky;
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus();

  alu_issue_ctrl #(.DATA_W(DATA_W), .TAG_W(TAG_W), .RES_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_ctrl        (alu_ctrl),
    .alu_z           (alu_z),
    .alu_ovf         (alu_ovf),
    .stat_clr        (stat_clr),
    .stat_ops        (stat_ops),
    .stat_ovf_sticky (stat_ovf_sticky)
  );

  // Registered ALU model; unknown op codes return a+b with ovf=1 as junk.
  logic [63:0] sum, dif;
  logic        add_v, sub_v;
  assign sum   = alu_a + alu_b;
  assign dif   = alu_a - alu_b;
  assign add_v = (alu_a[63] == alu_b[63]) && (sum[63] != alu_a[63]);
  assign sub_v = (alu_a[63] != alu_b[63]) && (dif[63] != alu_a[63]);

  always @(posedge clk) begin
    alu_ovf <= 1'b0;
    case (alu_ctrl)
      ALU_ADD:   begin alu_z <= sum; alu_ovf <= add_v; end
      ALU_SUB:   begin alu_z <= dif; alu_ovf <= sub_v; end
      ALU_AND:   alu_z <= alu_a & alu_b;
      ALU_OR:    alu_z <= alu_a | alu_b;
      ALU_XOR:   alu_z <= alu_a ^ alu_b;
      ALU_NOR:   alu_z <= ~(alu_a | alu_b);
      ALU_SLL:   alu_z <= alu_a << alu_b[5:0];
      ALU_SRL:   alu_z <= alu_a >> alu_b[5:0];
      ALU_ASR:   alu_z <= $signed(alu_a) >>> alu_b[5:0];
      ALU_CMPEQ: alu_z <= {63'd0, alu_a == alu_b};
      ALU_CMPLT: alu_z <= {63'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_CMPGT: alu_z <= {63'd0, $signed(alu_a) > $signed(alu_b)};
      default:   begin alu_z <= sum; alu_ovf <= 1'b1; end
    endcase
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (alu_a !== 64'd0) begin failures++; $display("FAIL reset_alu_a got=%h exp=0", alu_a); end
    checks++; if (alu_ctrl !== 4'd0) begin failures++; $display("FAIL reset_alu_ctrl got=%h exp=0", alu_ctrl); end
    reset = 1'b0;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (stat_ops !== 32'd0) begin failures++; $display("FAIL reset_stat_ops got=%0d exp=0", stat_ops); end
  endtask

  task automatic test_single_add();
    bus.out_ready = 1'b0;
    drive_op(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd3);
    step();
    bus.in_valid = 1'b0;
    checks++; if (alu_a !== 64'h7FFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL add_alu_a got=%h exp=7fffffffffffffff", alu_a); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid1 got=%0b exp=0", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid2 got=%0b exp=0", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.out_z !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL add_z got=%h exp=8000000000000000", bus.out_z); end
    checks++; if (bus.out_ovf !== 1'b1) begin failures++; $display("FAIL add_ovf got=%0b exp=1", bus.out_ovf); end
    checks++; if (bus.out_tag !== 5'd3) begin failures++; $display("FAIL add_tag got=%0d exp=3", bus.out_tag); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_popped got=%0b exp=0", bus.out_valid); end
    checks++; if (stat_ops !== 32'd1) begin failures++; $display("FAIL add_stat_ops got=%0d exp=1", stat_ops); end
    checks++; if (stat_ovf_sticky !== 1'b1) begin failures++; $display("FAIL add_sticky got=%0b exp=1", stat_ovf_sticky); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4];
    logic [63:0] as [4];
    logic [63:0] bs [4];
    logic [63:0] exp_z [4];
    ops   = '{ALU_SUB, ALU_AND, ALU_CMPLT, ALU_ASR};
    as    = '{64'd10, 64'hF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    bs    = '{64'd3, 64'h3C, 64'd1, 64'd4};
    exp_z = '{64'd7, 64'h30, 64'd1, 64'hF800_0000_0000_0000};
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive_op(ops[c], as[c], bs[c], 5'(c + 1));
      else bus.in_valid = 1'b0;
      if (c < 7) begin
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready c=%0d got=%0b exp=1", c, bus.in_ready); end
      end
      if (c >= 3 && c <= 6) begin
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid c=%0d got=%0b exp=1", c, bus.out_valid); end
        checks++; if (bus.out_z !== exp_z[c-3]) begin failures++; $display("FAIL b2b_z c=%0d got=%h exp=%h", c, bus.out_z, exp_z[c-3]); end
        checks++; if (bus.out_tag !== 5'(c - 2)) begin failures++; $display("FAIL b2b_tag c=%0d got=%0d exp=%0d", c, bus.out_tag, c - 2); end
      end
      if (c == 7) begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0b exp=0", bus.out_valid); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        drive_op(ALU_ADD, 64'(c), 64'd100, 5'(8 + c));
        if (bus.in_ready === 1'b1) acc++;
      end else bus.in_valid = 1'b0;
      step();
    end
    checks++; if (acc != 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low c=%0d got=%0b exp=0", c, bus.in_ready); end
      checks++; if (bus.out_z !== 64'd100 || bus.out_tag !== 5'd8) begin failures++; $display("FAIL bp_stable c=%0d got=%0d/%0d exp=100/8", c, bus.out_z, bus.out_tag); end
      step();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_pop_cycle_ready got=%0b exp=0", bus.in_ready); end
      end
      if (k == 1) begin
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_after_pop_ready got=%0b exp=1", bus.in_ready); end
      end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid k=%0d got=%0b exp=1", k, bus.out_valid); end
      checks++; if (bus.out_z !== 64'(100 + k) || bus.out_tag !== 5'(8 + k)) begin failures++; $display("FAIL bp_drain k=%0d got=%0d/%0d exp=%0d/%0d", k, bus.out_z, bus.out_tag, 100 + k, 8 + k); end
      step();
    end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b exp=0", bus.out_valid); end
    checks++; if (stat_ops !== 32'd9) begin failures++; $display("FAIL bp_stat_ops got=%0d exp=9", stat_ops); end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b0;
    drive_op(4'b1110, 64'd5, 64'd5, 5'd7);
    step();
    bus.in_valid = 1'b0;
    checks++; if (alu_ctrl !== 4'b1110) begin failures++; $display("FAIL ill_alu_ctrl got=%b exp=1110", alu_ctrl); end
    step(); step();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ill_valid got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.out_z !== 64'd0) begin failures++; $display("FAIL ill_z got=%h exp=0", bus.out_z); end
    checks++; if (bus.out_illegal !== 1'b1) begin failures++; $display("FAIL ill_flag got=%0b exp=1", bus.out_illegal); end
    checks++; if (bus.out_ovf !== 1'b0) begin failures++; $display("FAIL ill_ovf got=%0b exp=0", bus.out_ovf); end
    checks++; if (bus.out_tag !== 5'd7) begin failures++; $display("FAIL ill_tag got=%0d exp=7", bus.out_tag); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (stat_ops !== 32'd10) begin failures++; $display("FAIL ill_stat_ops got=%0d exp=10", stat_ops); end
  endtask

  task automatic test_reset_inflight();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_op(ALU_ADD, 64'd1, 64'd1, 5'(20 + c));
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd20) begin failures++; $display("FAIL rst_pre got=%0b/%0d exp=1/20", bus.out_valid, bus.out_tag); end
    reset = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (stat_ops !== 32'd0) begin failures++; $display("FAIL rst_stat_ops got=%0d exp=0", stat_ops); end
    checks++; if (stat_ovf_sticky !== 1'b0) begin failures++; $display("FAIL rst_sticky got=%0b exp=0", stat_ovf_sticky); end
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_stale c=%0d got=%0b exp=0", c, bus.out_valid); end
    end
    drive_op(ALU_ADD, 64'd2, 64'd2, 5'd9);
    step();
    bus.in_valid = 1'b0;
    step(); step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_z !== 64'd4 || bus.out_tag !== 5'd9) begin failures++; $display("FAIL rst_new_add got=%0b/%0d/%0d exp=1/4/9", bus.out_valid, bus.out_z, bus.out_tag); end
    step();
    checks++; if (stat_ops !== 32'd1) begin failures++; $display("FAIL rst_new_stat got=%0d exp=1", stat_ops); end
  endtask

  task automatic test_stat_clr();
    bus.out_ready = 1'b0;
    drive_op(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd1);
    step();
    bus.in_valid = 1'b0;
    step(); step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ovf !== 1'b1) begin failures++; $display("FAIL clr_pre got=%0b/%0b exp=1/1", bus.out_valid, bus.out_ovf); end
    bus.out_ready = 1'b1;
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    checks++; if (stat_ops !== 32'd0) begin failures++; $display("FAIL clr_stat_ops got=%0d exp=0", stat_ops); end
    checks++; if (stat_ovf_sticky !== 1'b0) begin failures++; $display("FAIL clr_sticky got=%0b exp=0", stat_ovf_sticky); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL clr_popped got=%0b exp=0", bus.out_valid); end
  endtask

  initial begin
    reset         = 1'b1;
    stat_clr      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_inflight();
    test_stat_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/collect controller that sits in front of the 64-bit execute ALU.
- Accepts decoded operations from the decode/register-read stage over a valid/ready handshake and drives the ALU's A, B and aluctrl inputs.
- Tracks each operation through the ALU's single registered stage and captures Z and overflow into a result FIFO.
- Presents results to writeback over a second valid/ready handshake, with credit-based backpressure.

Parameters:
- DATA_W, 64, operand and result width.
- TAG_W, 5, destination-register tag carried alongside each operation.
- RES_DEPTH, 4, result FIFO entries; must be a power of 2 and at least 4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  controller can accept an operation.
- in_op  input  4  ALU operation code (0000 ADD … 1011 CMPGT).
- in_a  input  DATA_W  operand A.
- in_b  input  DATA_W  operand B.
- in_tag  input  TAG_W  destination tag.
- alu_a  output  DATA_W  to ALU A.
- alu_b  output  DATA_W  to ALU B.
- alu_ctrl  output  4  to ALU aluctrl.
- alu_z  input  DATA_W  registered ALU result.
- alu_ovf  input  1  registered ALU overflow.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts the result.
- out_z  output  DATA_W  result value.
- out_ovf  output  1  overflow; forced 0 unless the op was ADD or SUB.
- out_tag  output  TAG_W  destination tag.
- out_illegal  output  1  op code was 1100–1111; out_z is 0.
- stat_clr  input  1  clears the statistics counters.
- stat_ops  output  32  count of retired results.
- stat_ovf_sticky  output  1  set when any retired result had out_ovf=1.

Behaviour:
- Pipeline for an operation accepted at edge N (in_valid & in_ready sampled high):
  - Edge N: S1 registers alu_a, alu_b, alu_ctrl, tag, an illegal flag and an add/sub flag; s1_valid=1.
  - Edge N+1: the ALU registers Z; S2 takes S1's metadata; s2_valid=1.
  - Edge N+2: the FIFO writes {alu_z, alu_ovf & addsub, tag, illegal}.
  - out_valid is high from edge N+2 onward (visible in the cycle after edge N+2). Minimum accept-to-out_valid is 3 cycles.
- ALU-driving outputs:
  - alu_a, alu_b and alu_ctrl come only from S1 registers; no combinational path from in_* to alu_*.
  - When S1 is empty they hold their last value; the ALU's result is then discarded because s2_valid=0.
- Credit rule:
  - in_ready = (fifo_count + s1_valid + s2_valid) < RES_DEPTH, computed from registered state only.
  - No combinational path from out_ready to in_ready.
  - A pop in the same cycle does not raise in_ready until the next cycle.
  - FIFO overflow is therefore impossible. An assertion must check that S2 never writes when the FIFO is full.
- Output side:
  - out_* comes from the FIFO head; out_valid = (fifo_count != 0).
  - A pop occurs on out_valid & out_ready.
  - out_z, out_ovf, out_tag and out_illegal must be stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - Count is unchanged and both pointers advance.
  - A push into an empty FIFO with out_ready=1 still takes one cycle to appear; there is no bypass.
- Pointers wrap modulo RES_DEPTH. Count is log2(RES_DEPTH)+1 bits wide.
- Sustained throughput is one op per cycle when out_ready is held at 1.
- Statistics:
  - stat_ops increments on each pop and wraps at 2^32.
  - stat_ovf_sticky sets on a pop with out_ovf=1.
  - When stat_clr coincides with a pop, the clear wins: stat_ops=0 and sticky=0.
- Reset:
  - Clears s1_valid, s2_valid, FIFO pointers/count, stat_ops and stat_ovf_sticky.
  - alu_a=0, alu_b=0, alu_ctrl=0, in_ready=0 during reset, out_valid=0.
  - In-flight operations are dropped. in_ready returns to 1 in the first cycle after reset deasserts.
- Illegal ops are issued to the ALU unchanged and retired in order with out_illegal=1. No stall, no exception.

Decomposition:
- Shared package alu_pkg:
  - 4-bit op-code constants ALU_ADD … ALU_CMPGT.
  - ALU_OP_MAX = 4'b1011.
  - Helper function is_addsub(op).
- One natural sub-module: alu_res_fifo, a synchronous FIFO parameterised by width and depth with push/pop/count.

Test Plan:
- Single ADD: in_a=0x7FFF_FFFF_FFFF_FFFF, in_b=1, tag=3 → out_valid in cycle N+3, out_z=0x8000_0000_0000_0000, out_ovf=1, out_tag=3, stat_ovf_sticky=1.
- Back-to-back stream with out_ready=1: SUB 10-3, AND 0xF0&0x3C, CMPLT -1<1, ASR 0x8000…0>>>4 on tags 1–4 → in-order results 7, 0x30, 1, 0xF800_0000_0000_0000, one per cycle, in_ready never drops.
- Backpressure: out_ready=0, offer 6 ops → exactly 4 accepted, in_ready low thereafter, outputs stable; release out_ready → 4 results drain in order, in_ready rises the cycle after the first pop.
- Illegal op 1110 with A=5, B=5, tag=7 → out_z=0, out_illegal=1, out_ovf=0, stat_ops incremented.
- Reset with 2 ops in flight and 1 in the FIFO → next cycle out_valid=0, stat_ops=0, no stale result ever appears; a new ADD 2+2 retires 4.
- stat_clr asserted on the same cycle as a pop → stat_ops=0 after the edge; sticky cleared.
